// File: rtl/x_or_reduce_pipe.sv
// rtl/x_or_reduce_pipe.sv - pipelined radix-4 OR reduction with lowest-index report and sticky event capture
module x_or_reduce_pipe #(
   parameter int    WIDTH  = 32,
   parameter string LOC    = "UNPLACED",
   localparam int   IW     = $clog2(WIDTH),
   localparam int   STAGES = ($clog2(WIDTH) + 1) / 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   input  logic             CLR,
   output logic             O,
   output logic [IW-1:0]    O_IDX,
   output logic             O_VALID,
   output logic             STICKY,
   output logic [IW-1:0]    STICKY_IDX
);

   localparam int PW = 4 ** STAGES;

   logic [WIDTH-1:0] in_q;
   logic [PW-1:0]    leaf;
   logic [STAGES:0]  vld_q;
   logic             fin_or;
   logic [IW-1:0]    fin_idx;

   // LOC carries placement only; no logic depends on it.
   if (LOC == "") begin : g_unplaced
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         in_q  <= '0;
         vld_q <= '0;
      end else begin
         in_q  <= I;
         vld_q <= {vld_q[STAGES-1:0], I_VALID};
      end
   end

   always_comb begin
      leaf             = '0;
      leaf[WIDTH-1:0]  = in_q;
   end

   for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
      localparam int N  = 4 ** (STAGES - k);
      // The root index is trimmed to IW; its dropped high bits are always 0.
      localparam int XW = (k == STAGES) ? IW : 2 * k;

      logic [N-1:0]         or_d;
      logic [N-1:0]         or_n;
      logic [N-1:0]         or_q;
      logic [N-1:0][XW-1:0] idx_d;
      logic [N-1:0][XW-1:0] idx_n;
      logic [N-1:0][XW-1:0] idx_q;

      if (k == 1) begin : g_src
         always_comb begin
            or_d  = '0;
            idx_d = '0;
            for (int n = 0; n < N; n++) begin
               or_d[n] = |leaf[4*n +: 4];
               for (int j = 3; j >= 0; j--)
                  idx_d[n] = leaf[4*n+j] ? XW'(j) : idx_d[n];
            end
         end
      end else begin : g_src
         always_comb begin
            or_d  = '0;
            idx_d = '0;
            for (int n = 0; n < N; n++) begin
               or_d[n] = |g_lvl[k-1].or_q[4*n +: 4];
               for (int j = 3; j >= 0; j--)
                  idx_d[n] = g_lvl[k-1].or_q[4*n+j]
                           ? XW'({2'(j), g_lvl[k-1].idx_q[4*n+j]})
                           : idx_d[n];
            end
         end
      end

      // Invalid slots travel as zeros so the root needs no separate forcing.
      assign or_n  = vld_q[k-1] ? or_d  : '0;
      assign idx_n = vld_q[k-1] ? idx_d : '0;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            or_q  <= '0;
            idx_q <= '0;
         end else begin
            or_q  <= or_n;
            idx_q <= idx_n;
         end
      end
   end

   assign fin_or  = g_lvl[STAGES].or_n[0];
   assign fin_idx = g_lvl[STAGES].idx_n[0];

   // A coincident event beats CLR so that no event is lost.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         STICKY     <= 1'b0;
         STICKY_IDX <= '0;
      end else if (fin_or && (!STICKY || CLR)) begin
         STICKY     <= 1'b1;
         STICKY_IDX <= fin_idx;
      end else if (CLR) begin
         STICKY     <= 1'b0;
         STICKY_IDX <= '0;
      end
   end

   assign O       = g_lvl[STAGES].or_q[0];
   assign O_IDX   = g_lvl[STAGES].idx_q[0];
   assign O_VALID = vld_q[STAGES];

endmodule

// File: tb/tb_x_or_reduce_pipe.sv
// tb/tb_x_or_reduce_pipe.sv - self-checking bench for x_or_reduce_pipe at WIDTH 32, 5 and 1024
module tb_x_or_reduce_pipe;

   localparam int LAT = 4;

   typedef struct packed {
      logic        v;
      logic [31:0] d;
   } samp_t;

   typedef struct {
      logic [31:0] vec;
      logic        vld;
      logic        exp_o;
      logic [4:0]  exp_idx;
      logic        exp_v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i32 = '0;
   logic        v32 = 1'b0;
   logic        clr = 1'b0;
   logic        o32, ov32, s32;
   logic [4:0]  oi32, si32;

   logic [4:0]  i5 = '0;
   logic        v5 = 1'b0;
   logic        o5, ov5, s5;
   logic [2:0]  oi5, si5;

   logic [1023:0] i1k = '0;
   logic          v1k = 1'b0;
   logic          o1k, ov1k, s1k;
   logic [9:0]    oi1k, si1k;

   logic        clr_x = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   samp_t       hist[$];
   logic        exp_sticky;
   logic [4:0]  exp_sidx;
   vec_t        tbl[8];

   always #5 clk = ~clk;

   x_or_reduce_pipe #(.WIDTH(32)) u_dut (
      .CLK(clk), .RST_N(rst_n), .I(i32), .I_VALID(v32), .CLR(clr),
      .O(o32), .O_IDX(oi32), .O_VALID(ov32), .STICKY(s32), .STICKY_IDX(si32));

   x_or_reduce_pipe #(.WIDTH(5)) u_w5 (
      .CLK(clk), .RST_N(rst_n), .I(i5), .I_VALID(v5), .CLR(clr_x),
      .O(o5), .O_IDX(oi5), .O_VALID(ov5), .STICKY(s5), .STICKY_IDX(si5));

   x_or_reduce_pipe #(.WIDTH(1024)) u_w1k (
      .CLK(clk), .RST_N(rst_n), .I(i1k), .I_VALID(v1k), .CLR(clr_x),
      .O(o1k), .O_IDX(oi1k), .O_VALID(ov1k), .STICKY(s1k), .STICKY_IDX(si1k));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] lowest(input logic [31:0] d);
      for (int b = 0; b < 32; b++)
         if (d[b]) return 5'(b);
      return 5'd0;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (LAT - 1) hist.push_back('{1'b0, 32'd0});
      exp_sticky = 1'b0;
      exp_sidx   = 5'd0;
   endtask

   // One clock: drive, let the edge happen, advance the reference, compare.
   task automatic cycle(input logic [31:0] d, input logic vl, input logic c);
      samp_t      s;
      logic       eo;
      logic [4:0] ei;
      i32 = d;
      v32 = vl;
      clr = c;
      @(posedge clk);
      hist.push_back('{vl, d});
      s  = hist.pop_front();
      eo = s.v && (s.d != 32'd0);
      ei = s.v ? lowest(s.d) : 5'd0;
      if (eo && (!exp_sticky || c)) begin
         exp_sticky = 1'b1;
         exp_sidx   = ei;
      end else if (c) begin
         exp_sticky = 1'b0;
         exp_sidx   = 5'd0;
      end
      #1;
      chk("o", o32, eo);
      chk("o_idx", oi32, ei);
      chk("o_valid", ov32, s.v);
      chk("sticky", s32, exp_sticky);
      chk("sticky_idx", si32, exp_sidx);
   endtask

   initial begin
      logic [31:0] rd;
      logic        rv, rc;
      int          mode;

      tbl[0] = '{32'h8000_0000, 1'b1, 1'b1, 5'd31, 1'b1};
      tbl[1] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b1};
      tbl[2] = '{32'h0000_0006, 1'b1, 1'b1, 5'd1,  1'b1};
      tbl[3] = '{32'h0001_0000, 1'b1, 1'b1, 5'd16, 1'b1};
      tbl[4] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  1'b0};
      tbl[5] = '{32'h0000_0001, 1'b1, 1'b1, 5'd0,  1'b1};
      tbl[6] = '{32'hF000_0000, 1'b1, 1'b1, 5'd28, 1'b1};
      tbl[7] = '{32'h0040_0400, 1'b1, 1'b1, 5'd10, 1'b1};

      // Reset held with active stimulus
      i32 = 32'hFFFF_FFFF;
      v32 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_o", o32, 0);
      chk("rst_o_idx", oi32, 0);
      chk("rst_o_valid", ov32, 0);
      chk("rst_sticky", s32, 0);
      chk("rst_sticky_idx", si32, 0);
      chk("rst_w5_valid", ov5, 0);
      chk("rst_w1k_valid", ov1k, 0);
      rst_n = 1'b1;
      model_reset();

      cycle(32'h0000_0100, 1'b1, 1'b0);
      repeat (3) cycle(32'd0, 1'b0, 1'b0);
      chk("first_o", o32, 1);
      chk("first_idx", oi32, 8);
      chk("first_valid", ov32, 1);
      chk("first_sticky", s32, 1);
      chk("first_sticky_idx", si32, 8);
      cycle(32'd0, 1'b0, 1'b0);
      chk("first_single_pulse", ov32, 0);

      // Clear alone
      cycle(32'd0, 1'b0, 1'b1);
      chk("clr_sticky", s32, 0);
      chk("clr_sticky_idx", si32, 0);

      // Table-driven streaming, back to back
      for (int i = 0; i < 8 + LAT - 1; i++) begin
         if (i < 8) cycle(tbl[i].vec, tbl[i].vld, 1'b0);
         else       cycle(32'd0, 1'b0, 1'b0);
         if (i >= LAT - 1) begin
            chk("tbl_o", o32, tbl[i-LAT+1].exp_o);
            chk("tbl_idx", oi32, tbl[i-LAT+1].exp_idx);
            chk("tbl_valid", ov32, tbl[i-LAT+1].exp_v);
         end
      end
      chk("tbl_sticky_idx_held", si32, 31);

      // CLR on the same edge that delivers an event
      cycle(32'h0000_0020, 1'b1, 1'b0);
      repeat (2) cycle(32'd0, 1'b0, 1'b0);
      cycle(32'd0, 1'b0, 1'b1);
      chk("clrset_sticky", s32, 1);
      chk("clrset_sticky_idx", si32, 5);
      cycle(32'd0, 1'b0, 1'b1);
      chk("clr2_sticky", s32, 0);

      // Randomized traffic against the reference
      for (int n = 0; n < 400; n++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0:       rd = 32'd0;
            1:       rd = 32'd1 << $urandom_range(0, 31);
            2:       rd = $urandom;
            default: rd = $urandom & $urandom & $urandom & $urandom;
         endcase
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 9) == 0);
         cycle(rd, rv, rc);
      end

      // Reset while three vectors are in flight
      cycle(32'h0000_0001, 1'b1, 1'b0);
      cycle(32'h0000_0002, 1'b1, 1'b0);
      cycle(32'h0000_0004, 1'b1, 1'b0);
      v32   = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_sticky", s32, 0);
      chk("midrst_async_valid", ov32, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < LAT + 2; n++) begin
         cycle(32'd0, 1'b0, 1'b0);
         chk("midrst_no_valid", ov32, 0);
      end

      // Narrow and wide instances
      chk("w5_sticky_idle", s5, 0);
      i5        = 5'b10000;
      v5        = 1'b1;
      i1k       = '0;
      i1k[1023] = 1'b1;
      v1k       = 1'b1;
      cycle(32'd0, 1'b0, 1'b0);
      i5  = '0;
      v5  = 1'b0;
      i1k = '0;
      v1k = 1'b0;
      for (int e = 2; e <= 7; e++) begin
         cycle(32'd0, 1'b0, 1'b0);
         if (e == 2) chk("w5_early_valid", ov5, 0);
         if (e == 3) begin
            chk("w5_o", o5, 1);
            chk("w5_idx", oi5, 4);
            chk("w5_valid", ov5, 1);
            chk("w5_sticky_idx", si5, 4);
         end
         if (e == 4) chk("w5_after_valid", ov5, 0);
         if (e == 5) chk("w1k_early_valid", ov1k, 0);
         if (e == 6) begin
            chk("w1k_o", o1k, 1);
            chk("w1k_idx", oi1k, 1023);
            chk("w1k_valid", ov1k, 1);
            chk("w1k_sticky_idx", si1k, 1023);
         end
         if (e == 7) chk("w1k_after_valid", ov1k, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/x_or_reduce_pipe.md
# x_or_reduce_pipe

Parametrised, pipelined successor to the fixed 32-input OR primitive. It OR-reduces a WIDTH-bit vector through a registered radix-4 tree and reports three things: the reduced value, the index of the lowest asserted bit, and a sticky event flag with a captured index. It is used as an event/interrupt aggregator wherever a wide OR would otherwise limit timing. It replaces chains of flat OR cells in the simulation and primitive layer.

## Interface
Parameters:
- WIDTH, 32, number of request inputs; legal range 2..1024.
- IW, derived as ceil(log2(WIDTH)), width of the index outputs; not overridable.
- STAGES, derived as ceil(log4(WIDTH)), number of tree levels; 1 for WIDTH 2..4, 3 for WIDTH 32.
- LOC, "UNPLACED", placement attribute; has no functional effect.

Ports:
- CLK  input  1  clock. Every state element updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- I  input  WIDTH  request vector; bit 0 is the lowest index.
- I_VALID  input  1  qualifies I on the current edge.
- CLR  input  1  synchronous clear of the sticky state.
- O  output  1  registered OR of the sampled vector.
- O_IDX  output  IW  lowest asserted bit index of the sampled vector; 0 when O=0.
- O_VALID  output  1  qualifies O and O_IDX.
- STICKY  output  1  set by any valid result with O=1; held until cleared.
- STICKY_IDX  output  IW  O_IDX of the first such result after the last clear or reset.

## Operation
- **Input stage.** On each edge, I is registered into the stage-0 data register and I_VALID into the valid pipe. There is no stall and no ready signal: the pipe advances every cycle.
- **Tree stages 1..STAGES.** Each node combines up to 4 children from the previous stage.
  - Node OR = OR of the child ORs.
  - Node index = {child number, child index} of the lowest-numbered child whose OR is 1; 0 if no child is set.
  - Missing children, where WIDTH is not a power of 4, are tied to 0.
- **Output registers.** The last stage is the output register. O, O_IDX and O_VALID always hold the last stage.
  - When O_VALID=0, O and O_IDX are forced to 0.
- **Sticky logic.** Evaluated on each edge, using the O_VALID, O and O_IDX values about to be loaded:
  - set = (new O_VALID=1 and new O=1).
  - If STICKY=0 and set=1: STICKY goes to 1 and STICKY_IDX loads the new O_IDX.
  - If STICKY=1: STICKY_IDX holds; later events do not overwrite it.
  - CLR=1 with set=0: STICKY goes to 0 and STICKY_IDX to 0.
  - CLR=1 with set=1 on the same edge: the set wins, so no event is lost. STICKY stays or becomes 1 and STICKY_IDX loads the new O_IDX, because the clear takes effect first.
- **X handling** (simulation). If any valid input bit is 1, O is 1 even when other bits are X. Otherwise an X input yields X on O and O_IDX.

## Timing
- **Reset values.** With RST_N low, immediately and asynchronously: O=0, O_IDX=0, O_VALID=0, STICKY=0, STICKY_IDX=0, and all pipe registers 0.
- **Reset release.** Deassertion is sampled synchronously. The first input is captured on the first rising edge with RST_N high.
- **Latency.** LAT = STAGES+1 edges from the edge that samples I/I_VALID to O_VALID. This is 4 for WIDTH 32 and 2 for WIDTH 4.
- **Throughput.** One vector per cycle. Back-to-back valid inputs produce back-to-back valid outputs in the same order.
- **Sticky timing.**
  - STICKY rises on the same edge as the O_VALID/O=1 result that sets it.
  - CLR acts on the edge where it is sampled.
- **Reset mid-operation.** All in-flight vectors are discarded; no valid output is produced for them after release.

## Test plan
WIDTH=32, LAT=4 throughout.
- **Reset.** Hold RST_N=0 with I=all-ones and I_VALID=1 -> all outputs stay 0. Release, then drive I=32'h0000_0100 with I_VALID=1 for one cycle -> exactly 4 edges later O=1, O_IDX=8, O_VALID=1 for one cycle; STICKY=1 and STICKY_IDX=8.
- **Streaming.** Drive 32'h8000_0000, 0, 32'h0000_0006 and 32'h0001_0000 on consecutive valid cycles -> outputs in order: (1,31), (0,0), (1,1), (1,16). STICKY_IDX stays 31.
- **Clear.** Pulse CLR alone -> STICKY=0 and STICKY_IDX=0 on the next edge. Then pulse CLR on the same edge that delivers O=1, O_IDX=5 -> STICKY=1, STICKY_IDX=5.
- **Invalid input.** Drive I=32'hFFFF_FFFF with I_VALID=0 -> O_VALID=0, O=0, O_IDX=0 and STICKY is unchanged.
- **Reset mid-pipe.** Launch three valid vectors, assert RST_N low for one cycle while they are in the pipe, then release -> no valid output appears; all outputs are 0.
- **Non-power-of-4 width.** Rerun at WIDTH=5 (STAGES=2, LAT=3) with I=5'b10000 -> O=1, O_IDX=4 after 3 edges. Rerun at WIDTH=1024 with only bit 1023 set -> O_IDX=1023 after LAT=6 edges.
